// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer behind the UART receiver.
// Holds {error vector, data} entries in a circular FIFO. A character that
// arrives while the buffer is full is dropped. The drop raises the sticky
// overrun flag and marks the next stored entry's overrun error bit.
module uart_rx_fifo #(
    parameter int DATA_W    = 8,
    parameter int ERR_W     = 3,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AFULL_LVL = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ERR_W-1:0]  wr_err,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [ERR_W-1:0]  rd_err,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              overrun,
    input  logic              ovr_clr
);

    localparam int CW    = ADDR_W + 1;
    localparam int ENT_W = DATA_W + ERR_W;
    localparam logic [ADDR_W:0] DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_C = CW'(AFULL_LVL);

    logic [ENT_W-1:0]  mem_q [DEPTH];

    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ERR_W-1:0]  rd_err_q, rd_err_d;
    logic              rd_valid_q, rd_valid_d;
    logic              empty_q, full_q, afull_q;

    logic              rd_acc;
    logic              wr_acc;
    logic              wr_rej;
    logic [ERR_W-1:0]  wr_err_mark;
    logic [ENT_W-1:0]  rd_entry;

    // A full buffer still accepts a write when a read frees a slot in the same cycle.
    assign rd_acc      = rd_en && (count_q != '0);
    assign wr_acc      = wr_en && ((count_q != DEPTH_C) || rd_acc);
    assign wr_rej      = wr_en && !wr_acc;
    // Bit 1 of the error field carries a pending drop into the next stored entry.
    assign wr_err_mark = wr_err | (ERR_W'(pend_q) << 1);
    assign rd_entry    = mem_q[rp_q];

    // Next-state logic for pointers, occupancy, overrun tracking and read port.
    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        rd_valid_d = 1'b0;

        if (wr_acc) begin
            wp_d   = wp_q + ADDR_W'(1);
            pend_d = 1'b0;
        end else if (wr_rej) begin
            pend_d = 1'b1;
        end

        if (rd_acc) begin
            rp_d       = rp_q + ADDR_W'(1);
            rd_data_d  = rd_entry[DATA_W-1:0];
            rd_err_d   = rd_entry[ENT_W-1:DATA_W];
            rd_valid_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (wr_rej) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    // Control and output registers; status flags are decoded from the next-state count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            rd_valid_q <= rd_valid_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == DEPTH_C);
            afull_q    <= (count_d >= AFULL_C);
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wp_q] <= {wr_err_mark, wr_data};
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_err      = rd_err_q;
    assign rd_valid    = rd_valid_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overrun     = ovr_q;

endmodule
